// File: rtl/or_reduce_arbiter.sv
// Round-robin arbiter sharing one 8-bit OR-reduction unit between NREQ requesters.
// Optional build macro OR_REDUCE_EARLY_EXIT_EN: finish the scan at the first nonzero chunk.
module or_reduce_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_any,
    output logic                    rsp_zero,
    output logic [IDW-1:0]          rsp_id
);

    localparam int unsigned CHUNKS = WIDTH / 8;
    localparam int unsigned IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    id_q;
    logic [WIDTH-1:0]  word_q;
    logic [IDXW-1:0]   idx;
    logic              acc;

    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic [WIDTH-1:0]  grant_data;
    logic              chunk_nz;
    logic              last_chunk;
    logic              acc_next;
    logic              scan_end;

    // Round-robin search starting just after the most recently served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last_grant) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(grant_idx) == i) begin
                grant_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The latched word is shifted down so the shared reducer always sees bits [7:0].
    assign chunk_nz   = |word_q[7:0];
    assign last_chunk = (idx == IDXW'(CHUNKS - 1));
    assign acc_next   = acc | chunk_nz;

`ifdef OR_REDUCE_EARLY_EXIT_EN
    assign scan_end = last_chunk | chunk_nz;
`else
    assign scan_end = last_chunk;
`endif

    assign rsp_zero = ~rsp_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_any    <= 1'b0;
            rsp_id     <= '0;
            acc        <= 1'b0;
            idx        <= '0;
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            word_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        word_q     <= grant_data;
                        id_q       <= grant_idx;
                        acc        <= 1'b0;
                        idx        <= '0;
                        last_grant <= grant_idx;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    word_q <= word_q >> 8;
                    acc    <= acc_next;
                    if (scan_end) begin
                        rsp_any   <= acc_next;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_reduce_arbiter.sv
// Self-checking bench for or_reduce_arbiter: cycle model plus directed and random traffic.
module tb_or_reduce_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 16;
    localparam int IDW    = 2;
    localparam int CHUNKS = WIDTH / 8;
    localparam int NRAND  = 2500;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_any;
    logic                  rsp_zero;
    logic [IDW-1:0]        rsp_id;

    or_reduce_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_any   (rsp_any),
        .rsp_zero  (rsp_zero),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cons   = 0;
    int rsp_log[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference behaviour: who wins, how long the scan lasts, what the answer is.
    function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int exp_lat(input logic [WIDTH-1:0] w);
`ifdef OR_REDUCE_EARLY_EXIT_EN
        for (int k = 0; k < CHUNKS; k++) begin
            if (w[8*k +: 8] != 8'h00) return k + 1;
        end
`endif
        return (w == w) ? CHUNKS : CHUNKS;
    endfunction

    int               m_phase, m_cnt, m_last, m_gid, m_id, m_acc_cnt = 0;
    int               mg, mg2;
    logic             m_vld, m_any;
    logic [WIDTH-1:0] m_word;
    logic [NREQ-1:0]  exp_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_vld   <= 1'b0;
            m_any   <= 1'b0;
            m_id    <= 0;
            m_last  <= NREQ - 1;
            m_cnt   <= 0;
        end else begin
            case (m_phase)
                0: begin
                    mg = exp_grant(req_valid, m_last);
                    if (mg >= 0) begin
                        m_word    <= req_data[mg*WIDTH +: WIDTH];
                        m_gid     <= mg;
                        m_last    <= mg;
                        m_cnt     <= exp_lat(req_data[mg*WIDTH +: WIDTH]);
                        m_phase   <= 1;
                        m_acc_cnt <= m_acc_cnt + 1;
                    end
                end
                1: begin
                    if (m_cnt == 1) begin
                        m_phase <= 2;
                        m_vld   <= 1'b1;
                        m_any   <= (m_word != '0);
                        m_id    <= m_gid;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        m_vld   <= 1'b0;
                        m_phase <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_rdy = '0;
            if (m_phase == 0) begin
                mg2 = exp_grant(req_valid, m_last);
                if (mg2 >= 0) exp_rdy[mg2] = 1'b1;
            end
            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, m_vld);
            check("rsp_any", rsp_any, m_any);
            check("rsp_zero", rsp_zero, !m_any);
            check("rsp_id", rsp_id, m_id);
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id));
                n_cons++;
            end
        end
    end

    task automatic send_wait(input int id, input logic [WIDTH-1:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        req_data[id*WIDTH +: WIDTH] = w;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #2;
        req_valid[id] = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
    endtask

    task automatic consume();
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(posedge clk); #2 rsp_ready = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 200 && rsp_log.size() < n; k++) @(negedge clk);
        if (rsp_log.size() < n) check("log_timeout", rsp_log.size(), n);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    int lat, acc0, cons0, nacc;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] pending, acc_now;

    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_any", rsp_any, 0);
        check("reset_rsp_zero", rsp_zero, 1);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_req_ready", req_ready, 0);

        // Zero word from requester 2 straight out of reset.
        @(posedge clk); #2;
        req_data[2*WIDTH +: WIDTH] = 16'h0000;
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0100);
        @(posedge clk); #2 req_valid = '0;
        measure_latency(lat);
        check("t1_latency", lat, 2);
        check("t1_any", rsp_any, 0);
        check("t1_zero", rsp_zero, 1);
        check("t1_id", rsp_id, 2);
        consume();

        // Top-bit and bottom-bit words from requester 0.
        send_wait(0, 16'h8000);
        measure_latency(lat);
        check("t2_latency_8000", lat, 2);
        check("t2_any_8000", rsp_any, 1);
        check("t2_id_8000", rsp_id, 0);
        consume();
        send_wait(0, 16'h0001);
        measure_latency(lat);
`ifdef OR_REDUCE_EARLY_EXIT_EN
        check("t2_latency_0001", lat, 1);
`else
        check("t2_latency_0001", lat, 2);
`endif
        check("t2_any_0001", rsp_any, 1);
        consume();

        // All requesters valid from reset: strict rotation.
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        rsp_log.delete();
        req_data  = {16'h0000, 16'h1000, 16'h0000, 16'h0010};
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        wait_log(5);
        @(posedge clk); #2 req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < rsp_log.size()) check("t3_grant_order", rsp_log[k], exp_seq[k]);
        end
        repeat (10) @(posedge clk);
        #2 rsp_ready = 1'b0;

        // Stalled consumer: response held, no new grants.
        send_wait(3, 16'h0100);
        measure_latency(lat);
        check("t4_latency", lat, 2);
        @(posedge clk); #2;
        req_data[WIDTH-1:0] = 16'h0042;
        req_valid = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_any", rsp_any, 1);
            check("t4_hold_id", rsp_id, 3);
            check("t4_hold_ready", req_ready, 0);
        end
        @(posedge clk); #2;
        req_valid = '0;
        rsp_ready = 1'b1;
        rsp_log.delete();
        @(posedge clk); #2 rsp_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_one_consumed", rsp_log.size(), 1);

        // Reset while a word is being scanned.
        rsp_ready = 1'b1;
        send_wait(1, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_any", rsp_any, 0);
        check("t5_rst_id", rsp_id, 0);
        check("t5_rst_ready", req_ready, 0);
        rsp_log.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t5_no_response", rsp_log.size(), 0);
        @(posedge clk); #2;
        req_data[0 +: WIDTH]       = 16'h0000;
        req_data[3*WIDTH +: WIDTH] = 16'h0200;
        req_valid = 4'b1001;
        @(negedge clk);
        check("t5_first_grant", req_ready, 4'b0001);
        wait_log(2);
        @(posedge clk); #2 req_valid = '0;
        if (rsp_log.size() >= 2) begin
            check("t5_order0", rsp_log[0], 0);
            check("t5_order1", rsp_log[1], 3);
        end
        repeat (10) @(posedge clk);
        #2 rsp_ready = 1'b0;

        // Random traffic with honest requesters and a random consumer.
        acc0    = m_acc_cnt;
        cons0   = n_cons;
        nacc    = 0;
        pending = '0;
        for (int cyc = 0; cyc < 60000 && nacc < NRAND; cyc++) begin
            @(negedge clk);
            acc_now = req_valid & req_ready;
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_now[i]) begin
                    pending[i] = 1'b0;
                    nacc++;
                end
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = rand_word();
                end
            end
            req_valid = pending;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("t6_accepts", nacc, NRAND);
        check("t6_no_lost_or_dup", n_cons - cons0, m_acc_cnt - acc0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
